// File: rtl/dla_walker_engine.sv
// dla_walker_engine: grows a DLA cluster in a shared req/gnt SRAM framebuffer.
// Define DLA_STATS_EN to build the oSTEPS / oRESPAWNS counters.
module dla_walker_engine #(
  parameter int X_W = 10,
  parameter int Y_W = 10,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] PCOLOR = 16'hFFFF,
  parameter int CNT_W = 16,
  parameter int NEIGH8 = 0,
  parameter int MAX_STEPS = 4096,
  parameter logic [30:0] SEED_X = 31'd263245,
  parameter logic [30:0] SEED_Y = 31'd372345
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSTART,
  input  logic              iABORT,
  input  logic [X_W-1:0]    iSEED_X,
  input  logic [Y_W-1:0]    iSEED_Y,
  input  logic [CNT_W-1:0]  iTARGET,
  output logic              oMEM_REQ,
  output logic              oMEM_WE,
  output logic [X_W+Y_W-1:0] oMEM_ADDR,
  output logic [DATA_W-1:0] oMEM_WDATA,
  input  logic              iMEM_GNT,
  input  logic              iMEM_RVALID,
  input  logic [DATA_W-1:0] iMEM_RDATA,
  output logic              oBUSY,
  output logic              oDONE,
  output logic [CNT_W-1:0]  oCOUNT,
  output logic [31:0]       oSTEPS,
  output logic [15:0]       oRESPAWNS
);

  localparam int SW = $clog2(MAX_STEPS + 1);
  localparam logic [X_W:0] XLIM = (X_W+1)'(H_RES);
  localparam logic [Y_W:0] YLIM = (Y_W+1)'(V_RES);
  localparam logic [SW-1:0] SMAX = SW'(MAX_STEPS);
  localparam logic [2:0] NB_LAST = (NEIGH8 != 0) ? 3'd7 : 3'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_SEED, S_SPAWN, S_RD_CTR, S_RD_NB,
    S_STICK, S_STEP, S_DRAIN, S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [30:0] lfx_q, lfy_q;
  logic [X_W-1:0] sx_q, sx_d, wx_q, wx_d;
  logic [Y_W-1:0] sy_q, sy_d, wy_q, wy_d;
  logic [CNT_W-1:0] tgt_q, tgt_d, cnt_q, cnt_d, cnt_inc;
  logic [2:0] nb_q, nb_d;
  logic [SW-1:0] steps_q, steps_d, steps_inc;
  logic pend_q, pend_d;
  logic [X_W:0] ndx, nx, tx;
  logic [Y_W:0] ndy, ny, ty;
  logic nb_ok, st_ok, sp_ok, busy, start_ok, abort_ok;
  logic mem_st, req, gnt, rd_gnt, rd_ok, hit, timeout;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= S_IDLE;
      lfx_q   <= SEED_X;
      lfy_q   <= SEED_Y;
      sx_q    <= '0;
      sy_q    <= '0;
      wx_q    <= '0;
      wy_q    <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      nb_q    <= '0;
      steps_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfx_q   <= {lfx_q[29:0], lfx_q[30] ^ lfx_q[27]};
      lfy_q   <= {lfy_q[29:0], lfy_q[30] ^ lfy_q[24]};
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      nb_q    <= nb_d;
      steps_q <= steps_d;
      pend_q  <= pend_d;
    end
  end

  // Neighbour scan order: W, E, N, S, NW, NE, SW, SE
  always_comb begin
    ndx = '0;
    ndy = '0;
    unique case (nb_q)
      3'd0: ndx = '1;
      3'd1: ndx = (X_W+1)'(1);
      3'd2: ndy = '1;
      3'd3: ndy = (Y_W+1)'(1);
      3'd4: begin ndx = '1; ndy = '1; end
      3'd5: begin ndx = (X_W+1)'(1); ndy = '1; end
      3'd6: begin ndx = '1; ndy = (Y_W+1)'(1); end
      default: begin ndx = (X_W+1)'(1); ndy = (Y_W+1)'(1); end
    endcase
  end

  // One extra bit turns -1 underflow into a value above the limit
  assign nx = {1'b0, wx_q} + ndx;
  assign ny = {1'b0, wy_q} + ndy;
  assign nb_ok = (nx < XLIM) && (ny < YLIM);
  assign tx = lfx_q[0] ? {1'b0, wx_q} + 1'b1 : {1'b0, wx_q} - 1'b1;
  assign ty = lfy_q[0] ? {1'b0, wy_q} + 1'b1 : {1'b0, wy_q} - 1'b1;
  assign st_ok = (tx < XLIM) && (ty < YLIM);
  assign sp_ok = ({1'b0, lfx_q[X_W-1:0]} < XLIM) &&
                 ({1'b0, lfy_q[Y_W-1:0]} < YLIM);

  assign steps_inc = steps_q + 1'b1;
  assign timeout = steps_inc == SMAX;
  assign cnt_inc = cnt_q + 1'b1;

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign start_ok = !busy && iSTART && !iABORT;
  assign abort_ok = busy && iABORT && (state_q != S_DRAIN);

  assign mem_st = (state_q == S_SEED) || (state_q == S_RD_CTR) ||
                  (state_q == S_RD_NB) || (state_q == S_STICK);
  assign req = mem_st && !pend_q && ((state_q != S_RD_NB) || nb_ok);
  assign oMEM_REQ = req;
  assign oMEM_WE = (state_q == S_SEED) || (state_q == S_STICK);
  assign oMEM_WDATA = PCOLOR;
  assign gnt = req && iMEM_GNT;
  assign rd_gnt = gnt && !oMEM_WE;
  assign rd_ok = pend_q && iMEM_RVALID;
  assign hit = iMEM_RDATA == PCOLOR;

  always_comb begin
    oMEM_ADDR = {wx_q, wy_q};
    unique case (1'b1)
      state_q == S_SEED:  oMEM_ADDR = {sx_q, sy_q};
      state_q == S_RD_NB: oMEM_ADDR = {nx[X_W-1:0], ny[Y_W-1:0]};
      default:            oMEM_ADDR = {wx_q, wy_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    nb_d    = nb_q;
    steps_d = steps_q;
    pend_d  = (pend_q && !iMEM_RVALID) || rd_gnt;
    unique case (state_q)
      S_IDLE, S_DONE: if (start_ok) begin
        sx_d    = iSEED_X;
        sy_d    = iSEED_Y;
        tgt_d   = iTARGET;
        cnt_d   = '0;
        state_d = S_SEED;
      end
      S_SEED: if (gnt) state_d = (tgt_q == '0) ? S_DONE : S_SPAWN;
      S_SPAWN: if (sp_ok) begin
        wx_d    = lfx_q[X_W-1:0];
        wy_d    = lfy_q[Y_W-1:0];
        steps_d = '0;
        state_d = S_RD_CTR;
      end
      S_RD_CTR: if (rd_ok) begin
        nb_d    = '0;
        state_d = hit ? S_SPAWN : S_RD_NB;
      end
      S_RD_NB: begin
        if (rd_ok && hit) state_d = S_STICK;
        else if (rd_ok || !nb_ok) begin
          if (nb_q == NB_LAST) state_d = S_STEP;
          else nb_d = nb_q + 3'd1;
        end
      end
      S_STICK: if (gnt) begin
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == tgt_q) ? S_DONE : S_SPAWN;
      end
      S_STEP: begin
        steps_d = steps_inc;
        if (!st_ok || timeout) state_d = S_SPAWN;
        else begin
          wx_d    = tx[X_W-1:0];
          wy_d    = ty[Y_W-1:0];
          state_d = S_RD_CTR;
        end
      end
      S_DRAIN: if (iMEM_RVALID) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A grant on the abort edge completes but never bumps the count
    if (abort_ok) begin
      cnt_d   = cnt_q;
      state_d = pend_d ? S_DRAIN : S_IDLE;
    end
  end

  assign oBUSY  = busy;
  assign oDONE  = state_q == S_DONE;
  assign oCOUNT = cnt_q;

`ifdef DLA_STATS_EN
  logic [31:0] nst_q;
  logic [15:0] nrs_q;
  logic st_inc, rs_inc;

  assign st_inc = (state_q == S_STEP) && !abort_ok;
  assign rs_inc = st_inc && (!st_ok || timeout);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      nst_q <= '0;
      nrs_q <= '0;
    end else if (start_ok) begin
      nst_q <= '0;
      nrs_q <= '0;
    end else begin
      if (st_inc && !(&nst_q)) nst_q <= nst_q + 1'b1;
      if (rs_inc && !(&nrs_q)) nrs_q <= nrs_q + 1'b1;
    end
  end

  assign oSTEPS    = nst_q;
  assign oRESPAWNS = nrs_q;
`else
  assign oSTEPS    = '0;
  assign oRESPAWNS = '0;
`endif

endmodule

// File: tb/tb_dla_walker_engine.sv
// tb_dla_walker_engine: directed bench for dla_walker_engine on a 12x10
// image behind an SRAM model with adjustable grant stalls and read latency.
module tb_dla_walker_engine;

  localparam int XW = 4;
  localparam int YW = 4;
  localparam int HR = 12;
  localparam int VR = 10;
  localparam logic [15:0] PC = 16'hFFFF;
  localparam logic [7:0] SEED_A = 8'h57;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iSTART = 1'b0, iABORT = 1'b0;
  logic [XW-1:0] iSEED_X = '0;
  logic [YW-1:0] iSEED_Y = '0;
  logic [15:0] iTARGET = '0;
  logic oMEM_REQ, oMEM_WE;
  logic [7:0] oMEM_ADDR;
  logic [15:0] oMEM_WDATA;
  logic iMEM_GNT = 1'b0, iMEM_RVALID = 1'b0;
  logic [15:0] iMEM_RDATA = '0;
  logic oBUSY, oDONE;
  logic [15:0] oCOUNT;
  logic [31:0] oSTEPS;
  logic [15:0] oRESPAWNS;

  always #5 clk = ~clk;

  dla_walker_engine #(
    .X_W(XW), .Y_W(YW), .H_RES(HR), .V_RES(VR), .DATA_W(16),
    .PCOLOR(PC), .CNT_W(16), .NEIGH8(0), .MAX_STEPS(64)
  ) dut (
    .iCLK(clk), .iRST(rst), .iSTART(iSTART), .iABORT(iABORT),
    .iSEED_X(iSEED_X), .iSEED_Y(iSEED_Y), .iTARGET(iTARGET),
    .oMEM_REQ(oMEM_REQ), .oMEM_WE(oMEM_WE), .oMEM_ADDR(oMEM_ADDR),
    .oMEM_WDATA(oMEM_WDATA), .iMEM_GNT(iMEM_GNT),
    .iMEM_RVALID(iMEM_RVALID), .iMEM_RDATA(iMEM_RDATA),
    .oBUSY(oBUSY), .oDONE(oDONE), .oCOUNT(oCOUNT),
    .oSTEPS(oSTEPS), .oRESPAWNS(oRESPAWNS)
  );

  // memory model configuration, written by the stimulus only
  int stall_max = 0, lat_min = 1, lat_max = 1;
  bit hold_wr = 1'b0;

  // memory model state, written by the model only
  logic [15:0] mem [256];
  bit rd_pend, req_seen, prev_req, prev_gnt, prev_we;
  logic [7:0] rd_addr, prev_addr, last_waddr;
  int stall_left, rv_wait;
  int wr_cnt, rd_gnt_cnt, req_cycles;
  int viol_stab, viol_out, viol_edge;

  always @(negedge clk) begin
    if (rst) begin
      foreach (mem[i]) mem[i] = '0;
      rd_pend = 1'b0;
      req_seen = 1'b0;
      prev_req = 1'b0;
      iMEM_GNT = 1'b0;
      iMEM_RVALID = 1'b0;
      wr_cnt = 0;
    end else begin
      if (prev_req && !prev_gnt &&
          !(oMEM_REQ && oMEM_WE == prev_we && oMEM_ADDR == prev_addr))
        viol_stab++;
      if (oMEM_REQ && rd_pend) viol_out++;
      if (oMEM_REQ && (oMEM_ADDR[7:4] >= HR || oMEM_ADDR[3:0] >= VR))
        viol_edge++;
      if (oMEM_REQ) req_cycles++;
      iMEM_RVALID = 1'b0;
      if (rd_pend) begin
        if (rv_wait == 0) begin
          iMEM_RVALID = 1'b1;
          iMEM_RDATA = mem[rd_addr];
          rd_pend = 1'b0;
        end else rv_wait--;
      end
      iMEM_GNT = 1'b0;
      if (oMEM_REQ && !rd_pend && !(hold_wr && oMEM_WE)) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          stall_left = $urandom_range(stall_max, 0);
        end
        if (stall_left == 0) begin
          iMEM_GNT = 1'b1;
          req_seen = 1'b0;
          if (oMEM_WE) begin
            mem[oMEM_ADDR] = oMEM_WDATA;
            last_waddr = oMEM_ADDR;
            wr_cnt++;
          end else begin
            rd_pend = 1'b1;
            rd_addr = oMEM_ADDR;
            rv_wait = int'($urandom_range(lat_max, lat_min)) - 1;
            rd_gnt_cnt++;
          end
        end else stall_left--;
      end
      prev_req = oMEM_REQ;
      prev_gnt = iMEM_GNT;
      prev_we = oMEM_WE;
      prev_addr = oMEM_ADDR;
    end
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    iSTART = 1'b0;
    iABORT = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] x, input logic [3:0] y,
                           input logic [15:0] t);
    @(negedge clk);
    iSEED_X = x;
    iSEED_Y = y;
    iTARGET = t;
    iSTART = 1'b1;
    @(posedge clk);
    #1 iSTART = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!oDONE && n < 30000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, oDONE, 1);
  endtask

  function automatic bit filled(input int x, input int y);
    if (x < 0 || y < 0 || x >= HR || y >= VR) return 1'b0;
    return mem[x*16 + y] == PC;
  endfunction

  task automatic scan_image(output int nfill, output int nbad);
    int x, y;
    nfill = 0;
    nbad = 0;
    for (int a = 0; a < 256; a++) begin
      x = a / 16;
      y = a % 16;
      if (mem[a] == PC) begin
        nfill++;
        if (x >= HR || y >= VR) nbad++;
        else if (a != int'(SEED_A) &&
                 !(filled(x-1, y) || filled(x+1, y) ||
                   filled(x, y-1) || filled(x, y+1)))
          nbad++;
      end
    end
  endtask

  int nf, nb, base, rq, n;

  initial begin
    viol_stab = 0; viol_out = 0; viol_edge = 0;
    rd_gnt_cnt = 0; req_cycles = 0;

    // reset state
    do_reset();
    @(posedge clk);
    #1;
    check("rst_req", oMEM_REQ, 0);
    check("rst_busy", oBUSY, 0);
    check("rst_done", oDONE, 0);
    check("rst_count", oCOUNT, 0);
    check("rst_steps", oSTEPS, 0);
    check("rst_respawns", oRESPAWNS, 0);

    // zero target: seed write only
    start_run(4'd5, 4'd7, 16'd0);
    check("zt_busy", oBUSY, 1);
    check("zt_done_early", oDONE, 0);
    @(posedge clk);
    #1;
    check("zt_done", oDONE, 1);
    check("zt_busy_off", oBUSY, 0);
    repeat (3) @(posedge clk);
    #1;
    check("zt_writes", wr_cnt, 1);
    check("zt_addr", last_waddr, SEED_A);
    check("zt_data", mem[SEED_A], PC);
    check("zt_count", oCOUNT, 0);
    check("zt_req_idle", oMEM_REQ, 0);

    // stick run, no stalls; a start pulse mid-run must be ignored
    do_reset();
    start_run(4'd5, 4'd7, 16'd6);
    repeat (20) @(posedge clk);
    @(negedge clk);
    iTARGET = 16'd2;
    iSTART = 1'b1;
    @(posedge clk);
    #1 iSTART = 1'b0;
    wait_done("st_done");
    check("st_count", oCOUNT, 6);
    check("st_writes", wr_cnt, 7);
    scan_image(nf, nb);
    check("st_pixels", nf, 7);
    check("st_adjacent", nb, 0);
    check("st_steps_off", oSTEPS, 0);
    check("st_busy", oBUSY, 0);

    // stalled grants and variable read latency
    do_reset();
    stall_max = 5;
    lat_min = 1;
    lat_max = 4;
    start_run(4'd5, 4'd7, 16'd6);
    wait_done("hs_done");
    check("hs_count", oCOUNT, 6);
    scan_image(nf, nb);
    check("hs_pixels", nf, 7);
    check("hs_adjacent", nb, 0);
    @(posedge clk);
    #1;
    check("hs_done_hold", oDONE, 1);

    // restart straight from DONE, one more particle on the old cluster
    start_run(4'd5, 4'd7, 16'd1);
    check("rs_done_clr", oDONE, 0);
    wait_done("rs_done");
    check("rs_count", oCOUNT, 1);
    check("rs_writes", wr_cnt, 9);
    scan_image(nf, nb);
    check("rs_pixels", nf, 8);
    check("rs_adjacent", nb, 0);

    // abort while a neighbour read is outstanding, RVALID latency 3
    do_reset();
    stall_max = 0;
    lat_min = 3;
    lat_max = 3;
    start_run(4'd5, 4'd7, 16'd50);
    base = rd_gnt_cnt;
    n = 0;
    while (rd_gnt_cnt < base + 2 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("ab_read_seen", rd_gnt_cnt >= base + 2, 1);
    #1 iABORT = 1'b1;
    @(posedge clk);
    #1 iABORT = 1'b0;
    check("ab_req_drop", oMEM_REQ, 0);
    check("ab_drain_busy", oBUSY, 1);
    @(posedge clk);
    #1;
    check("ab_drain_wait", oBUSY, 1);
    @(posedge clk);
    #1;
    check("ab_idle", oBUSY, 0);
    check("ab_done", oDONE, 0);
    check("ab_count", oCOUNT, wr_cnt - 1);
    rq = req_cycles;
    repeat (10) @(posedge clk);
    #1;
    check("ab_no_req", req_cycles - rq, 0);

    // async reset while a STICK write is waiting for its grant
    do_reset();
    lat_min = 1;
    lat_max = 1;
    start_run(4'd5, 4'd7, 16'd20);
    n = 0;
    while (wr_cnt < 1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    hold_wr = 1'b1;
    n = 0;
    while (!(oMEM_REQ && oMEM_WE) && n < 30000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rr_stick_req", oMEM_REQ && oMEM_WE, 1);
    #2 rst = 1'b1;
    #1;
    check("rr_req", oMEM_REQ, 0);
    check("rr_count", oCOUNT, 0);
    check("rr_busy", oBUSY, 0);
    repeat (2) @(negedge clk);
    hold_wr = 1'b0;
    rst = 1'b0;
    start_run(4'd5, 4'd7, 16'd3);
    wait_done("rr_done");
    check("rr_final_count", oCOUNT, 3);
    scan_image(nf, nb);
    check("rr_pixels", nf, 4);
    check("rr_adjacent", nb, 0);

    // protocol monitors over the whole run
    check("stable_while_stalled", viol_stab, 0);
    check("one_outstanding", viol_out, 0);
    check("edge_addr", viol_edge, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
